id_ex_pipe_reg: RTL

ID/EX pipeline register of the 5-stage MIPS core. It captures decoded operands, the immediate, register addresses and control bits at the end of decode, and presents them to execute. Its `alu_src_out`, `rt_data_out` and `imm_out` drive the ALU-source 2:1 multiplexer directly: `sel` is `alu_src_out`, input 0 is `rt_data_out`, input 1 is `imm_out`. It supports hold (stall), bubble insertion (flush), and write-back refresh of held operands.

---
 rtl/id_ex_pipe_reg.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register of the 5-stage MIPS core.
//
// Captures decoded operands, the immediate, the register addresses and the
// control bits at the end of decode and presents them to execute.
// alu_src_out, rt_data_out and imm_out feed the ALU-source 2:1 mux directly.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   stall, flush          hold contents / load a bubble (flush wins)
//   valid_in              decode stage holds a real instruction
//   *_in                  operands, immediate, addresses, control bits
//   wb_reg_write/addr/data  write-back port used for load-time bypass and
//                         refresh of held operands while stalled
//   *_out                 registered copies of the matching inputs
//
// Optional feature: define ID_EX_PC_TRACE_EN to add pc_in/pc_out, which
// follow the data-field load/stall/flush rules and are never refreshed.
module id_ex_pipe_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        valid_in,
    input  logic [31:0] rs_data_in,
    input  logic [31:0] rt_data_in,
    input  logic [31:0] imm_in,
    input  logic [4:0]  rs_addr_in,
    input  logic [4:0]  rt_addr_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [3:0]  alu_op_in,
    input  logic        alu_src_in,
    input  logic        reg_dst_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
`ifdef ID_EX_PC_TRACE_EN
    input  logic [31:0] pc_in,
    output logic [31:0] pc_out,
`endif
    output logic        valid_out,
    output logic [31:0] rs_data_out,
    output logic [31:0] rt_data_out,
    output logic [31:0] imm_out,
    output logic [4:0]  rs_addr_out,
    output logic [4:0]  rt_addr_out,
    output logic [4:0]  rd_addr_out,
    output logic [3:0]  alu_op_out,
    output logic        alu_src_out,
    output logic        reg_dst_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        reg_write_out,
    output logic        mem_to_reg_out
);

    logic        valid_q,      valid_d;
    logic [31:0] rs_data_q,    rs_data_d;
    logic [31:0] rt_data_q,    rt_data_d;
    logic [31:0] imm_q,        imm_d;
    logic [4:0]  rs_addr_q,    rs_addr_d;
    logic [4:0]  rt_addr_q,    rt_addr_d;
    logic [4:0]  rd_addr_q,    rd_addr_d;
    logic [3:0]  alu_op_q,     alu_op_d;
    logic        alu_src_q,    alu_src_d;
    logic        reg_dst_q,    reg_dst_d;
    logic        mem_read_q,   mem_read_d;
    logic        mem_write_q,  mem_write_d;
    logic        reg_write_q,  reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
`ifdef ID_EX_PC_TRACE_EN
    logic [31:0] pc_q,         pc_d;
`endif

    // Write-back matches; register 0 is hardwired and never forwarded.
    logic wb_live;
    logic rs_hit_in, rt_hit_in, rs_hit_q, rt_hit_q;

    always_comb begin
        wb_live   = wb_reg_write && (wb_addr != '0);
        rs_hit_in = wb_live && (wb_addr == rs_addr_in);
        rt_hit_in = wb_live && (wb_addr == rt_addr_in);
        rs_hit_q  = wb_live && (wb_addr == rs_addr_q);
        rt_hit_q  = wb_live && (wb_addr == rt_addr_q);
    end

    always_comb begin
        // Default: hold everything.
        valid_d      = valid_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_d        = imm_q;
        rs_addr_d    = rs_addr_q;
        rt_addr_d    = rt_addr_q;
        rd_addr_d    = rd_addr_q;
        alu_op_d     = alu_op_q;
        alu_src_d    = alu_src_q;
        reg_dst_d    = reg_dst_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
`ifdef ID_EX_PC_TRACE_EN
        pc_d         = pc_q;
`endif

        if (flush) begin
            valid_d      = 1'b0;
            rs_data_d    = '0;
            rt_data_d    = '0;
            imm_d        = '0;
            rs_addr_d    = '0;
            rt_addr_d    = '0;
            rd_addr_d    = '0;
            alu_op_d     = '0;
            alu_src_d    = 1'b0;
            reg_dst_d    = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
`ifdef ID_EX_PC_TRACE_EN
            pc_d         = '0;
`endif
        end else if (stall) begin
            // Held operands track register-file writes made during the stall.
            if (rs_hit_q) rs_data_d = wb_data;
            if (rt_hit_q) rt_data_d = wb_data;
        end else begin
            valid_d   = valid_in;
            rs_data_d = rs_hit_in ? wb_data : rs_data_in;
            rt_data_d = rt_hit_in ? wb_data : rt_data_in;
            imm_d     = imm_in;
            rs_addr_d = rs_addr_in;
            rt_addr_d = rt_addr_in;
            rd_addr_d = rd_addr_in;
            // Control bits of a non-instruction are squashed to a bubble.
            alu_op_d     = valid_in ? alu_op_in     : '0;
            alu_src_d    = valid_in && alu_src_in;
            reg_dst_d    = valid_in && reg_dst_in;
            mem_read_d   = valid_in && mem_read_in;
            mem_write_d  = valid_in && mem_write_in;
            reg_write_d  = valid_in && reg_write_in;
            mem_to_reg_d = valid_in && mem_to_reg_in;
`ifdef ID_EX_PC_TRACE_EN
            pc_d         = pc_in;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            rd_addr_q    <= '0;
            alu_op_q     <= '0;
            alu_src_q    <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
`ifdef ID_EX_PC_TRACE_EN
            pc_q         <= '0;
`endif
        end else begin
            valid_q      <= valid_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_addr_q    <= rs_addr_d;
            rt_addr_q    <= rt_addr_d;
            rd_addr_q    <= rd_addr_d;
            alu_op_q     <= alu_op_d;
            alu_src_q    <= alu_src_d;
            reg_dst_q    <= reg_dst_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
`ifdef ID_EX_PC_TRACE_EN
            pc_q         <= pc_d;
`endif
        end
    end

    assign valid_out      = valid_q;
    assign rs_data_out    = rs_data_q;
    assign rt_data_out    = rt_data_q;
    assign imm_out        = imm_q;
    assign rs_addr_out    = rs_addr_q;
    assign rt_addr_out    = rt_addr_q;
    assign rd_addr_out    = rd_addr_q;
    assign alu_op_out     = alu_op_q;
    assign alu_src_out    = alu_src_q;
    assign reg_dst_out    = reg_dst_q;
    assign mem_read_out   = mem_read_q;
    assign mem_write_out  = mem_write_q;
    assign reg_write_out  = reg_write_q;
    assign mem_to_reg_out = mem_to_reg_q;
`ifdef ID_EX_PC_TRACE_EN
    assign pc_out         = pc_q;
`endif

endmodule
